// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one external iterative divider
// among N requesters.
//
// The winning request's operands are latched. The divider is then reset
// through div_start for one cycle, and the block waits for div_valid. The
// quotient and remainder go back to the winner with a one-cycle resp_valid
// pulse.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester request level / one-cycle accept pulse
//   req_D, req_d        packed dividends/divisors, requester i at [i*W +: W]
//   resp_valid          one-hot one-cycle result pulse to the owner
//   resp_q, resp_r      quotient/remainder, valid with resp_valid
//   busy                high whenever the FSM is not IDLE
//   div0                divide-by-zero flag, qualified by resp_valid
//   div_D, div_d        latched operands to the divider
//   div_start           divider reset (rst OR state START)
//   div_q, div_r        divider results
//   div_valid           divider done flag
//
// Optional feature: define DIV_ZERO_BYPASS_EN to answer zero-divisor
// requests directly (q = all ones, r = D, div0 = 1) without the divider.
// When it is not defined, div0 is tied low.
module div_sched #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_D,
  input  logic [N*W-1:0] req_d,
  output logic [N-1:0]   resp_valid,
  output logic [W-1:0]   resp_q,
  output logic [W-1:0]   resp_r,
  output logic           busy,
  output logic           div0,
  output logic [W-1:0]   div_D,
  output logic [W-1:0]   div_d,
  output logic           div_start,
  input  logic [W-1:0]   div_q,
  input  logic [W-1:0]   div_r,
  input  logic           div_valid
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [W-1:0]  opD_q, opD_d;
  logic [W-1:0]  opd_q, opd_d;
  logic [W-1:0]  resq_q, resq_d;
  logic [W-1:0]  resr_q, resr_d;
`ifdef DIV_ZERO_BYPASS_EN
  logic          div0_q, div0_d;
`endif

  logic          any_req;
  logic [IW-1:0] gsel;
  logic [W-1:0]  selD, seld;

  // Rotating-priority search: the first asserted request at or after the
  // pointer, wrapping modulo N.
  always_comb begin
    int unsigned   idx;
    logic [IW-1:0] cur;
    any_req = 1'b0;
    gsel    = '0;
    idx     = 0;
    cur     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      cur = IW'(idx);
      if (!any_req && req_valid[cur]) begin
        any_req = 1'b1;
        gsel    = cur;
      end
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    selD = '0;
    seld = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gsel == IW'(i)) begin
        selD = req_D[i*W +: W];
        seld = req_d[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    opD_d      = opD_q;
    opd_d      = opd_q;
    resq_d     = resq_q;
    resr_d     = resr_q;
`ifdef DIV_ZERO_BYPASS_EN
    div0_d     = div0_q;
`endif
    req_ready  = '0;
    resp_valid = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready[gsel] = 1'b1;
          gnt_d           = gsel;
          opD_d           = selD;
          opd_d           = seld;
          ptr_d           = (gsel == IW'(N - 1)) ? '0 : gsel + 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
          div0_d          = 1'b0;
          if (seld == '0) begin
            // Zero divisor: answer directly and leave the divider untouched.
            resq_d  = '1;
            resr_d  = selD;
            div0_d  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = START;
          end
`else
          state_d         = START;
`endif
        end
      end
      // div_valid may still be high from the previous operation here, so
      // it is not looked at until WAIT.
      START: state_d = WAIT;
      WAIT: begin
        if (div_valid) begin
          resq_d  = div_q;
          resr_d  = div_r;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid[gnt_q] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      opD_q   <= '0;
      opd_q   <= '0;
      resq_q  <= '0;
      resr_q  <= '0;
`ifdef DIV_ZERO_BYPASS_EN
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      opD_q   <= opD_d;
      opd_q   <= opd_d;
      resq_q  <= resq_d;
      resr_q  <= resr_d;
`ifdef DIV_ZERO_BYPASS_EN
      div0_q  <= div0_d;
`endif
    end
  end

  assign div_D     = opD_q;
  assign div_d     = opd_q;
  assign div_start = rst | (state_q == START);
  assign busy      = (state_q != IDLE);
  assign resp_q    = resq_q;
  assign resp_r    = resr_q;
`ifdef DIV_ZERO_BYPASS_EN
  assign div0      = div0_q & (state_q == RESP);
`else
  assign div0      = 1'b0;
`endif

endmodule
